// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, types and compare helper for the PWM peripheral
//   PWM_STEPS     steps per PWM period (step counter runs 0..PWM_LAST_STEP)
//   PWM_LAST_STEP last step value before the counter wraps to 0
//   N_PINS        number of output pins
//   DUTY_FULL     duty code that keeps the waveform high for the whole period
package pwm_pkg;
   localparam int         PWM_STEPS     = 255;
   localparam logic [7:0] PWM_LAST_STEP = 8'd254;
   localparam int         N_PINS        = 16;
   localparam logic [7:0] DUTY_FULL     = 8'hFF;

   typedef logic [7:0]        duty_t;
   typedef logic [N_PINS-1:0] pin_vec_t;

   // Full duty is special-cased so the waveform never drops at the wrap step.
   function automatic logic pwm_compare(input duty_t cnt, input duty_t duty);
      return (duty == DUTY_FULL) | (cnt < duty);
   endfunction
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: clock prescaler and 255-step PWM step counter
//   clk_i   in   system clock
//   rst_ni  in   synchronous active-low reset
//   cnt_o   out  current step, 0..254
//   tick_o  out  high on the last prescaler cycle of each step
//   wrap_o  out  high on the tick that moves the step counter from 254 to 0
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CLK_DIV    = 13,
   parameter int PRESCALE_W = 4
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   output duty_t cnt_o,
   output logic  tick_o,
   output logic  wrap_o
);
   localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(CLK_DIV - 1);

   logic [PRESCALE_W-1:0] presc_q, presc_d;
   duty_t                 cnt_q, cnt_d;
   logic                  tick, wrap;

   always_comb begin
      tick    = presc_q == PRESC_LAST;
      wrap    = tick & (cnt_q == PWM_LAST_STEP);
      presc_d = tick ? '0 : presc_q + PRESCALE_W'(1);
      cnt_d   = wrap ? '0 : (tick ? cnt_q + 8'd1 : cnt_q);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign tick_o = tick;
   assign wrap_o = wrap;
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 pins, each forced low, forced high, or driven by a shared 8-bit PWM
//   clk              in   system clock
//   rst_n            in   synchronous active-low reset
//   en_reg_out_7_0   in   pin drive enable, pins 7:0 (0 = pin low)
//   en_reg_out_15_8  in   pin drive enable, pins 15:8
//   en_reg_pwm_7_0   in   PWM select, pins 7:0 (0 = static high when enabled)
//   en_reg_pwm_15_8  in   PWM select, pins 15:8
//   pwm_duty_cycle   in   shared duty, 0x00 = never high, 0xFF = always high
//   out              out  registered pin outputs
//   period_start     out  one-cycle pulse as the step counter returns to 0
// Build option PWM_SYNC_UPDATE_EN: when defined, a new duty is taken only at the
// period boundary; otherwise it follows pwm_duty_cycle one clock later.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int CLK_DIV    = 13,
   parameter int PRESCALE_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);
   duty_t    cnt, duty_act_q, duty_act_d;
   pin_vec_t en_out, en_pwm, out_q, out_d;
   logic     wrap, pwm_hi, unused_tick;
   logic     first_q, period_start_q, period_start_d;

   pwm_timebase #(
      .CLK_DIV    (CLK_DIV),
      .PRESCALE_W (PRESCALE_W)
   ) u_timebase (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .cnt_o  (cnt),
      .tick_o (unused_tick),
      .wrap_o (wrap)
   );

   always_comb begin
      en_out = {en_reg_out_15_8, en_reg_out_7_0};
      en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
`ifdef PWM_SYNC_UPDATE_EN
      duty_act_d = wrap ? pwm_duty_cycle : duty_act_q;
`else
      duty_act_d = pwm_duty_cycle;
`endif
      pwm_hi         = pwm_compare(cnt, duty_act_q);
      out_d          = en_out & (~en_pwm | {N_PINS{pwm_hi}});
      // first_q marks the first clock after reset, which also begins a period
      period_start_d = wrap | first_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         duty_act_q     <= '0;
         out_q          <= '0;
         first_q        <= 1'b1;
         period_start_q <= 1'b0;
      end else begin
         duty_act_q     <= duty_act_d;
         out_q          <= out_d;
         first_q        <= 1'b0;
         period_start_q <= period_start_d;
      end
   end

   assign out          = out_q;
   assign period_start = period_start_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: randomized and directed checks against a time-based PWM model
module tb_pwm_peripheral;
   localparam int CLK_DIV = 13;
   localparam int P       = 255 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  en_reg_out_7_0 = '0, en_reg_out_15_8 = '0;
   logic [7:0]  en_reg_pwm_7_0 = '0, en_reg_pwm_15_8 = '0;
   logic [7:0]  pwm_duty_cycle = '0;
   logic [15:0] out;
   logic        period_start;

   int vec = 0, miss = 0;
   logic [16:0] exp_q[$];
   int          hi_q[$];

   int          mk = 0;
   logic [7:0]  mduty = '0;

   pwm_peripheral #(.CLK_DIV(CLK_DIV), .PRESCALE_W(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out             (out),
      .period_start    (period_start)
   );

   always #5 clk = ~clk;

   // Model: mk counts clock edges since reset release; the PWM phase follows
   // directly from elapsed time (CLK_DIV clocks per step, 255 steps per period).
   task automatic drive(input logic r, input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
      int pos, cnt;
      logic hi;
      logic [15:0] e_out;
      logic e_ps;
      @(negedge clk);
      rst_n = r;
      {en_reg_out_15_8, en_reg_out_7_0} = eo;
      {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
      pwm_duty_cycle = d;
      if (!r) begin
         mk = 0;
         mduty = '0;
         exp_q.push_back(17'h0);
      end else begin
         mk++;
         pos   = (mk - 1) % P;
         cnt   = pos / CLK_DIV;
         hi    = (mduty == 8'hFF) || (cnt < int'(mduty));
         e_out = eo & (~ep | {16{hi}});
         e_ps  = (mk == 1) || (mk % P == 0);
         exp_q.push_back({e_out, e_ps});
`ifdef PWM_SYNC_UPDATE_EN
         if (pos == P - 1) mduty = d;
`else
         mduty = d;
`endif
      end
   endtask

   task automatic run(input int n, input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
      for (int i = 0; i < n; i++) drive(1'b1, eo, ep, d);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, 8'h0);
   endtask

   // Monitor: per-cycle pin/pulse compare plus high-time per period on pin 1.
   initial begin
      logic [16:0] e;
      int hcnt, h;
      logic open;
      hcnt = 0;
      open = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vec++;
            if ({out, period_start} !== e) begin
               miss++;
               $display("FAIL cycle t=%0t out=%h ps=%b required out=%h ps=%b", $time, out, period_start, e[16:1], e[0]);
            end
         end
         if (!rst_n) begin
            open = 1'b0;
            hcnt = 0;
         end else begin
            if (period_start === 1'b1) begin
               if (open && hi_q.size() != 0) begin
                  h = hi_q.pop_front();
                  if (h >= 0) begin
                     vec++;
                     if (hcnt != h) begin
                        miss++;
                        $display("FAIL hi_time t=%0t high_clks=%0d required=%0d", $time, hcnt, h);
                     end
                  end
               end
               open = 1'b1;
               hcnt = 0;
            end
            if (open && out[1] === 1'b1) hcnt++;
         end
      end
   end

   task automatic sweep(input logic [7:0] d);
      do_reset(2);
      hi_q.push_back(-1);
      hi_q.push_back(-1);
      hi_q.push_back(d == 8'hFF ? P : int'(d) * CLK_DIV);
      run(3 * P + 2, 16'hFFFF, 16'hFFFF, d);
   endtask

   initial begin
      logic [15:0] eo, ep;
      logic [7:0]  d;
      do_reset(3);
      // reset in the middle of a period, then restart from step 0
      run(100 * CLK_DIV + 5, 16'hFFFF, 16'hFFFF, 8'h80);
      do_reset(3);
      run(40, 16'hFFFF, 16'hFFFF, 8'h80);
      // static modes
      run(4, 16'h00FF, 16'h0000, 8'h55);
      run(4, 16'h0000, 16'hFFFF, 8'hFF);
      run(4, 16'h0000, 16'h0000, 8'hFF);
      // duty sweep
      sweep(8'h00);
      sweep(8'h80);
      sweep(8'hFF);
      // mixed pins
      do_reset(2);
      hi_q.push_back(-1);
      hi_q.push_back(64 * CLK_DIV);
      run(2 * P + 2, 16'hFFFF, 16'hAAAA, 8'h40);
      // duty change mid-period at step 10, then a write on the wrap cycle
      do_reset(2);
      hi_q.push_back(-1);
`ifdef PWM_SYNC_UPDATE_EN
      hi_q.push_back(32 * CLK_DIV);
`else
      hi_q.push_back(192 * CLK_DIV);
`endif
      hi_q.push_back(192 * CLK_DIV);
      hi_q.push_back(192 * CLK_DIV);
      hi_q.push_back(16 * CLK_DIV);
      run(P + 130, 16'hFFFF, 16'hFFFF, 8'h20);
      run(3 * P - 131, 16'hFFFF, 16'hFFFF, 8'hC0);
      run(P + 3, 16'hFFFF, 16'hFFFF, 8'h10);
      // random traffic
      eo = 16'($urandom);
      ep = 16'($urandom);
      d  = 8'($urandom);
      for (int i = 0; i < 12000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            eo = 16'($urandom);
            ep = 16'($urandom);
         end
         if ($urandom_range(0, 299) == 0) d = 8'($urandom);
         drive($urandom_range(0, 1999) != 0, eo, ep, d);
      end
      @(negedge clk);
      @(negedge clk);
      vec++;
      if (exp_q.size() != 0 || hi_q.size() != 0) begin
         miss++;
         $display("FAIL drain pending_cycles=%0d pending_windows=%0d required=0", exp_q.size(), hi_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
